// File: rtl/core_pkg.sv
// Shared core-wide constants and helpers for fetch, decode and the datapath.
package core_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned InstrW = 32;

    localparam logic [XLEN-1:0] DefaultResetAddr = 32'h0000_0000;

    // Clears the byte-offset bits so every fetch address is word aligned.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & ~XLEN'(3);
    endfunction

endpackage

// File: rtl/fifo.sv
// Small synchronous FIFO with flush; flush wins over push and pop.
module fifo #(
    parameter int unsigned Width = 32,
    parameter int unsigned Depth = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  logic [Width-1:0]             wdata,
    output logic [Width-1:0]             rdata,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(Depth+1)-1:0]   count
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             push_en;
    logic             pop_en;

    assign full    = (count_q == CntW'(Depth));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign pop_en  = pop && !empty && !flush;
    assign push_en = push && (!full || pop_en) && !flush;
    // Gate the head so an empty FIFO presents zeros rather than stale storage.
    assign rdata   = empty ? '0 : mem_q[rd_ptr_q];

    // Next pointers and occupancy; pointers wrap explicitly at Depth.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_en) begin
                wr_ptr_d = (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + PtrW'(1);
            end
            if (pop_en) begin
                rd_ptr_d = (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + PtrW'(1);
            end
            unique case ({push_en, pop_en})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; reads of empty slots are masked above.
    always_ff @(posedge clk_i) begin
        if (push_en) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/fetch.sv
// Instruction fetch: pc generation, credit-limited imem requests, in-order
// response buffering and redirect flush with stale-response dropping.
module fetch
    import core_pkg::*;
#(
    parameter logic [XLEN-1:0] ResetAddr = DefaultResetAddr,
    parameter int unsigned     Depth     = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    output logic              imem_req_valid_o,
    input  logic              imem_req_ready_i,
    output logic [XLEN-1:0]   imem_req_addr_o,
    input  logic              imem_resp_valid_i,
    input  logic [InstrW-1:0] imem_resp_data_i,
    input  logic              redirect_valid_i,
    input  logic [XLEN-1:0]   redirect_addr_i,
    output logic              instr_valid_o,
    input  logic              instr_ready_i,
    output logic [InstrW-1:0] instr_o,
    output logic [XLEN-1:0]   pc_o
);

    localparam int unsigned CntW = $clog2(Depth + 1);
    // Two spare bits so the credit sum cannot wrap.
    localparam int unsigned SumW = CntW + 2;

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] head_pc_q, head_pc_d;
    logic [CntW-1:0] pend_q, pend_d;
    logic [CntW-1:0] drop_q, drop_d;
    logic            started_q;

    logic [CntW-1:0] cnt;
    logic            fifo_full;
    logic            fifo_empty;
    logic            fifo_push;
    logic            pop;
    logic            req_fire;
    logic            resp_fire;
    logic            resp_stale;
    logic [SumW-1:0] credit_sum;
    logic [XLEN-1:0] target;

    assign target     = word_align(redirect_addr_i);
    assign credit_sum = SumW'(cnt) + SumW'(pend_q) + SumW'(drop_q);

    // Request valid is a function of registered state only.
    assign imem_req_valid_o = started_q && (credit_sum < SumW'(Depth));
    assign imem_req_addr_o  = pc_q;
    assign req_fire         = imem_req_valid_o && imem_req_ready_i;

    assign resp_fire  = imem_resp_valid_i;
    assign resp_stale = (drop_q != '0);
    // Credit accounting keeps the full guard unreachable with a compliant memory.
    assign fifo_push  = resp_fire && !resp_stale && !redirect_valid_i && !fifo_full;

    assign instr_valid_o = !fifo_empty;
    assign pop           = instr_valid_o && instr_ready_i;
    assign pc_o          = head_pc_q;

    // Next pc, head pc and credit counters; redirect overrides everything.
    always_comb begin
        pc_d      = pc_q;
        head_pc_d = head_pc_q;
        pend_d    = pend_q;
        drop_d    = drop_q;
        if (redirect_valid_i) begin
            pc_d      = target;
            head_pc_d = target;
            pend_d    = '0;
            // Everything still owed by memory becomes stale, including a
            // request accepted this cycle; a response this cycle is consumed.
            drop_d    = drop_q + pend_q + CntW'(req_fire) - CntW'(resp_fire);
        end else begin
            if (req_fire) begin
                pc_d = pc_q + XLEN'(4);
            end
            if (pop) begin
                head_pc_d = head_pc_q + XLEN'(4);
            end
            pend_d = pend_q + CntW'(req_fire) - CntW'(resp_fire && !resp_stale);
            drop_d = drop_q - CntW'(resp_fire && resp_stale);
        end
    end

    // Fetch state registers; started_q opens the request path one cycle after reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q      <= ResetAddr;
            head_pc_q <= ResetAddr;
            pend_q    <= '0;
            drop_q    <= '0;
            started_q <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            head_pc_q <= head_pc_d;
            pend_q    <= pend_d;
            drop_q    <= drop_d;
            started_q <= 1'b1;
        end
    end

    fifo #(
        .Width (InstrW),
        .Depth (Depth)
    ) u_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push   (fifo_push),
        .pop    (pop),
        .flush  (redirect_valid_i),
        .wdata  (imem_resp_data_i),
        .rdata  (instr_o),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (cnt)
    );

endmodule

// File: tb/tb_fetch.sv
// Directed bench for fetch: 1-cycle in-order memory model with a response
// enable, a pop scoreboard on pc/instr, and immediate-assert comparisons.
module tb_fetch;

    localparam logic [31:0] RA = 32'h0000_0080;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_addr;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] pc;

    logic        resp_en;
    logic [31:0] mq[$];
    logic [31:0] exp_pc;
    int          tests = 0;
    int          fails = 0;
    int          pops  = 0;

    always #5 clk = ~clk;

    fetch #(
        .ResetAddr (RA),
        .Depth     (4)
    ) dut (
        .clk_i             (clk),
        .rst_ni            (rst_n),
        .imem_req_valid_o  (req_valid),
        .imem_req_ready_i  (req_ready),
        .imem_req_addr_o   (req_addr),
        .imem_resp_valid_i (resp_valid),
        .imem_resp_data_i  (resp_data),
        .redirect_valid_i  (redirect_valid),
        .redirect_addr_i   (redirect_addr),
        .instr_valid_o     (instr_valid),
        .instr_ready_i     (instr_ready),
        .instr_o           (instr),
        .pc_o              (pc)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {~a[15:0], a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    // Memory: accepted addresses queue up and return one per cycle while enabled.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid <= 1'b0;
            resp_data  <= '0;
            mq.delete();
        end else begin
            resp_valid <= 1'b0;
            if (resp_en && mq.size() != 0) begin
                resp_valid <= 1'b1;
                resp_data  <= mem_word(mq.pop_front());
            end
            if (req_valid && req_ready) mq.push_back(req_addr);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // One clock; checks every pop against the expected pc stream first.
    task automatic tick();
        if (instr_valid && instr_ready && !redirect_valid) begin
            chk("sb_pc", pc, exp_pc);
            chk("sb_instr", instr, mem_word(exp_pc));
            exp_pc = exp_pc + 32'd4;
            pops++;
        end
        if (redirect_valid) exp_pc = redirect_addr & 32'hFFFF_FFFC;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!instr_valid && n < 20) begin
            tick();
            n++;
        end
        chk(tag, {31'b0, instr_valid}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

    initial begin
        req_ready      = 1'b1;
        resp_en        = 1'b1;
        instr_ready    = 1'b1;
        redirect_valid = 1'b0;
        redirect_addr  = '0;
        exp_pc         = RA;

        // Reset values
        #12;
        chk("rst_req_valid", {31'b0, req_valid}, 32'd0);
        chk("rst_req_addr", req_addr, RA);
        chk("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_pc", pc, RA);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Start-up and streaming
        tick();
        chk("start_req_valid", {31'b0, req_valid}, 32'd1);
        chk("start_req_addr", req_addr, 32'h80);
        chk("start_empty", {31'b0, instr_valid}, 32'd0);
        tick();
        chk("req_addr_2", req_addr, 32'h84);
        tick();
        chk("lat_empty", {31'b0, instr_valid}, 32'd0);
        tick();
        chk("first_valid", {31'b0, instr_valid}, 32'd1);
        chk("first_pc", pc, 32'h80);
        chk("first_instr", instr, mem_word(32'h80));
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("stream_valid", {31'b0, instr_valid}, 32'd1);
        end

        // Backpressure: credits run out, then the stream resumes without gaps
        instr_ready = 1'b0;
        repeat (10) tick();
        chk("bp_req_stop", {31'b0, req_valid}, 32'd0);
        chk("bp_valid", {31'b0, instr_valid}, 32'd1);
        chk("bp_head_pc", pc, exp_pc);
        instr_ready = 1'b1;
        pops = 0;
        repeat (12) tick();
        chk("bp_resume_pops", pops, 32'd12);

        // Redirect with two live requests outstanding
        req_ready = 1'b0;
        repeat (6) tick();
        chk("drain_empty", {31'b0, instr_valid}, 32'd0);
        resp_en   = 1'b0;
        req_ready = 1'b1;
        tick();
        tick();
        req_ready      = 1'b0;
        redirect_valid = 1'b1;
        redirect_addr  = 32'h200;
        tick();
        redirect_valid = 1'b0;
        chk("rd_addr", req_addr, 32'h200);
        chk("rd_req_valid", {31'b0, req_valid}, 32'd1);
        chk("rd_empty", {31'b0, instr_valid}, 32'd0);
        resp_en   = 1'b1;
        req_ready = 1'b1;
        wait_valid("rd_wait");
        chk("rd_first_pc", pc, 32'h200);
        chk("rd_first_instr", instr, mem_word(32'h200));
        repeat (6) tick();

        // Redirect coinciding with request fire, response and pop
        chk("sim_setup_req", {31'b0, req_valid}, 32'd1);
        chk("sim_setup_out", {31'b0, instr_valid}, 32'd1);
        chk("sim_setup_resp", {31'b0, resp_valid}, 32'd1);
        redirect_valid = 1'b1;
        redirect_addr  = 32'h300;
        tick();
        redirect_valid = 1'b0;
        chk("sim_addr", req_addr, 32'h300);
        chk("sim_empty", {31'b0, instr_valid}, 32'd0);
        wait_valid("sim_wait");
        chk("sim_first_pc", pc, 32'h300);
        repeat (6) tick();

        // Misaligned redirect target
        redirect_valid = 1'b1;
        redirect_addr  = 32'h203;
        tick();
        redirect_valid = 1'b0;
        chk("mis_addr", req_addr, 32'h200);
        wait_valid("mis_wait");
        chk("mis_first_pc", pc, 32'h200);
        chk("mis_first_instr", instr, mem_word(32'h200));
        repeat (6) tick();

        // Fill to cnt=2, pend=2, then reset mid-cycle
        instr_ready = 1'b0;
        tick();
        chk("full_req_valid", {31'b0, req_valid}, 32'd0);
        chk("full_out_valid", {31'b0, instr_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_req_valid", {31'b0, req_valid}, 32'd0);
        chk("mrst_req_addr", req_addr, RA);
        chk("mrst_instr_valid", {31'b0, instr_valid}, 32'd0);
        chk("mrst_instr", instr, 32'd0);
        chk("mrst_pc", pc, RA);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n       = 1'b1;
        instr_ready = 1'b1;
        exp_pc      = RA;
        tick();
        chk("mrst_restart_valid", {31'b0, req_valid}, 32'd1);
        chk("mrst_restart_addr", req_addr, RA);
        wait_valid("mrst_wait");
        chk("mrst_first_pc", pc, RA);
        repeat (4) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
